// File: rtl/time_pkg.sv
// time_pkg: shared FSM states, edit-field codes, BCD limits and BCD inc/dec helpers
// Helpers treat an 8-bit value as two BCD digits {tens, units}; anything
// outside 00..lim (including non-decimal digits) is clamped to 00.
package time_pkg;
    typedef enum logic [1:0] {RUN, EDIT_H, EDIT_M, EDIT_S} state_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_H    = 2'd1;
    localparam logic [1:0] FLD_M    = 2'd2;
    localparam logic [1:0] FLD_S    = 2'd3;

    localparam logic [7:0] HOURS_MAX  = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= lim);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        return (!bcd_ok(v, lim) || v == lim) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
        return !bcd_ok(v, lim) ? 8'h00 :
               (v == 8'h00) ? lim :
               (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser, consecutive-cycle debounce and rising-edge press pulse
// Ports: i_clk, i_reset (async, active-high), i_btn (raw button),
//        o_press (one-cycle pulse, registered, on debounced rising edge).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic r_s1, r_s2, r_db, r_db_q, r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_db    <= 1'b0;
            r_db_q  <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_db_q  <= r_db;
            r_press <= r_db & ~r_db_q;
            // any cycle matching the accepted level restarts the count
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_db  <= r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: 1 Hz tick, midnight rollover and three-button time edit for the BCD clock
// Ports: i_clk, i_reset (async, active-high); i_btn_mode/up/down raw buttons;
//        i_cur_* current BCD time; o_tick count enable; o_load strobe with o_set_* digits;
//        o_edit_field (0 run, 1 h, 2 m, 3 s); o_blink field blink phase.
module time_set_ctrl
    import time_pkg::*;
#(
    parameter int CLK_HZ          = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 250_000,
    parameter int BLINK_HALF      = 12_500_000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_mode,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic [3:0] i_cur_h_t,
    input  logic [3:0] i_cur_h_u,
    input  logic [3:0] i_cur_m_t,
    input  logic [3:0] i_cur_m_u,
    input  logic [3:0] i_cur_s_t,
    input  logic [3:0] i_cur_s_u,
    output logic       o_tick,
    output logic       o_load,
    output logic [3:0] o_set_h_t,
    output logic [3:0] o_set_h_u,
    output logic [3:0] o_set_m_t,
    output logic [3:0] o_set_m_u,
    output logic [3:0] o_set_s_t,
    output logic [3:0] o_set_s_u,
    output logic [1:0] o_edit_field,
    output logic       o_blink
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    state_t        r_state, w_state;
    logic [PW-1:0] r_pre, w_pre;
    logic [BW-1:0] r_bcnt, w_bcnt;
    logic          r_tick, w_tick, r_load, w_load, r_blink, w_blink;
    logic [7:0]    r_h, r_m, r_s, w_h, w_m, w_s;
    logic [7:0]    w_h_adj, w_m_adj, w_s_adj;
    logic          w_mode, w_up, w_down, w_inc, w_dec, w_edit, w_midnight;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_mode), .o_press(w_mode));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_up), .o_press(w_up));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_down), .o_press(w_down));

    // mode masks up/down; simultaneous up+down cancel
    assign w_inc      = w_up & ~w_down & ~w_mode;
    assign w_dec      = w_down & ~w_up & ~w_mode;
    assign w_edit     = (r_state != RUN);
    assign w_midnight = ({i_cur_h_t, i_cur_h_u, i_cur_m_t, i_cur_m_u, i_cur_s_t, i_cur_s_u} == 24'h235959);
    assign w_h_adj    = w_inc ? bcd_inc(r_h, HOURS_MAX)  : w_dec ? bcd_dec(r_h, HOURS_MAX)  : r_h;
    assign w_m_adj    = w_inc ? bcd_inc(r_m, MINSEC_MAX) : w_dec ? bcd_dec(r_m, MINSEC_MAX) : r_m;
    assign w_s_adj    = w_inc ? bcd_inc(r_s, MINSEC_MAX) : w_dec ? bcd_dec(r_s, MINSEC_MAX) : r_s;

    always_comb begin
        w_state = r_state;
        w_h     = r_h;
        w_m     = r_m;
        w_s     = r_s;
        w_load  = 1'b0;
        w_tick  = !w_edit && (r_pre == PRE_MAX);
        w_pre   = (!w_edit && r_pre != PRE_MAX) ? r_pre + 1'b1 : '0;
        w_bcnt  = (w_edit && r_bcnt != BLINK_MAX) ? r_bcnt + 1'b1 : '0;
        w_blink = w_edit & (r_blink ^ (r_bcnt == BLINK_MAX));
        case (r_state)
            RUN: begin
                if (w_mode) begin
                    w_state       = EDIT_H;
                    {w_h, w_m, w_s} = {i_cur_h_t, i_cur_h_u, i_cur_m_t, i_cur_m_u, i_cur_s_t, i_cur_s_u};
                    w_blink       = 1'b1;
                end else if (w_tick && w_midnight) begin
                    w_load = 1'b1;
                    w_h    = '0;
                    w_m    = '0;
                    w_s    = '0;
                end
            end
            // a field change restarts the blink period without flipping the phase
            EDIT_H: begin
                w_h = w_h_adj;
                if (w_mode) begin
                    w_state = EDIT_M;
                    w_bcnt  = '0;
                    w_blink = r_blink;
                end
            end
            EDIT_M: begin
                w_m = w_m_adj;
                if (w_mode) begin
                    w_state = EDIT_S;
                    w_bcnt  = '0;
                    w_blink = r_blink;
                end
            end
            default: begin
                w_s = w_s_adj;
                if (w_mode) begin
                    w_state = RUN;
                    w_load  = 1'b1;
                    w_bcnt  = '0;
                    w_blink = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= RUN;
            r_pre   <= '0;
            r_bcnt  <= '0;
            r_tick  <= 1'b0;
            r_load  <= 1'b0;
            r_blink <= 1'b0;
            r_h     <= '0;
            r_m     <= '0;
            r_s     <= '0;
        end else begin
            r_state <= w_state;
            r_pre   <= w_pre;
            r_bcnt  <= w_bcnt;
            r_tick  <= w_tick;
            r_load  <= w_load;
            r_blink <= w_blink;
            r_h     <= w_h;
            r_m     <= w_m;
            r_s     <= w_s;
        end
    end

    assign o_tick       = r_tick;
    assign o_load       = r_load;
    assign o_blink      = r_blink;
    assign o_set_h_t    = r_h[7:4];
    assign o_set_h_u    = r_h[3:0];
    assign o_set_m_t    = r_m[7:4];
    assign o_set_m_u    = r_m[3:0];
    assign o_set_s_t    = r_s[7:4];
    assign o_set_s_u    = r_s[3:0];
    assign o_edit_field = (r_state == EDIT_H) ? FLD_H :
                          (r_state == EDIT_M) ? FLD_M :
                          (r_state == EDIT_S) ? FLD_S : FLD_NONE;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and randomized checks of time_set_ctrl against a decimal time model
module tb_time_set_ctrl;
    localparam int CLK_HZ = 10;
    localparam int DB     = 4;
    localparam int BH     = 3;
    localparam int LAT    = 2 + DB + 1 + 1;
    localparam int EV_MODE = 0, EV_UP = 1, EV_DN = 2, EV_BOTH = 3, EV_MODEUP = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic b_mode = 1'b0, b_up = 1'b0, b_dn = 1'b0;
    logic [3:0] cur [6];
    logic o_tick, o_load, o_blink;
    logic [3:0] o_set_h_t, o_set_h_u, o_set_m_t, o_set_m_u, o_set_s_t, o_set_s_u;
    logic [1:0] o_edit_field;

    time_set_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB), .BLINK_HALF(BH)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_btn_mode(b_mode), .i_btn_up(b_up), .i_btn_down(b_dn),
        .i_cur_h_t(cur[0]), .i_cur_h_u(cur[1]), .i_cur_m_t(cur[2]),
        .i_cur_m_u(cur[3]), .i_cur_s_t(cur[4]), .i_cur_s_u(cur[5]),
        .o_tick(o_tick), .o_load(o_load),
        .o_set_h_t(o_set_h_t), .o_set_h_u(o_set_h_u), .o_set_m_t(o_set_m_t),
        .o_set_m_u(o_set_m_u), .o_set_s_t(o_set_s_t), .o_set_s_u(o_set_s_u),
        .o_edit_field(o_edit_field), .o_blink(o_blink));

    always #5 clk = ~clk;

    int n_edge = 0;
    always @(posedge clk) n_edge <= n_edge + 1;

    int checks = 0, errors = 0;
    int m_field = 0, md [6], anchor = 0, banchor = 0, ev_edge = -1, ev_kind = 0;
    bit m_blink = 1'b0, exp_load = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_set();
        logic [23:0] e;
        for (int i = 0; i < 6; i++) e[23-4*i -: 4] = 4'(md[i]);
        return e;
    endfunction

    // field adjust in plain decimal: out-of-range clamps to 0, else wraps modulo (lim+1)
    task automatic adjust(input int f, input int dir);
        int idx, lim, v;
        idx = (f - 1) * 2;
        lim = (f == 1) ? 23 : 59;
        v = md[idx] * 10 + md[idx+1];
        if (md[idx] > 9 || md[idx+1] > 9 || v > lim) v = 0;
        else v = (dir > 0) ? (v + 1) % (lim + 1) : (v + lim) % (lim + 1);
        md[idx] = v / 10;
        md[idx+1] = v % 10;
    endtask

    task automatic apply(input int k);
        if (k == EV_MODE || k == EV_MODEUP) begin
            if (m_field == 0) begin
                m_field = 1;
                for (int i = 0; i < 6; i++) md[i] = int'(cur[i]);
                m_blink = 1'b1;
                banchor = n_edge;
            end else if (m_field < 3) begin
                m_field++;
                banchor = n_edge;
            end else begin
                m_field = 0;
                m_blink = 1'b0;
                exp_load = 1'b1;
                anchor = n_edge;
            end
        end else if (m_field != 0 && k != EV_BOTH) begin
            adjust(m_field, (k == EV_UP) ? 1 : -1);
        end
    endtask

    task automatic check_outputs();
        chk("tick", o_tick, 0);
        chk("load", o_load, 0);
        chk("field", o_edit_field, 0);
        chk("set", {o_set_h_t, o_set_h_u, o_set_m_t, o_set_m_u, o_set_s_t, o_set_s_u}, 0);
        chk("blink", o_blink, 0);
    endtask

    task automatic step();
        bit tk, mev;
        @(negedge clk);
        mev = (ev_edge == n_edge) && (ev_kind == EV_MODE || ev_kind == EV_MODEUP);
        tk = (m_field == 0) && (n_edge > anchor) && ((n_edge - anchor) % CLK_HZ == 0);
        exp_load = 1'b0;
        if (m_field != 0 && !mev && ((n_edge - banchor) % BH == 0)) m_blink = ~m_blink;
        if (ev_edge == n_edge) apply(ev_kind);
        if (tk && !mev && {cur[0], cur[1], cur[2], cur[3], cur[4], cur[5]} == 24'h235959) begin
            exp_load = 1'b1;
            for (int i = 0; i < 6; i++) md[i] = 0;
        end
        chk("tick", o_tick, tk);
        chk("load", o_load, exp_load);
        chk("field", o_edit_field, m_field);
        chk("set", {o_set_h_t, o_set_h_u, o_set_m_t, o_set_m_u, o_set_s_t, o_set_s_u}, exp_set());
        chk("blink", o_blink, m_blink);
    endtask

    task automatic press(input int k);
        ev_kind = k;
        ev_edge = n_edge + LAT;
        b_mode = (k == EV_MODE || k == EV_MODEUP);
        b_up   = (k == EV_UP || k == EV_BOTH || k == EV_MODEUP);
        b_dn   = (k == EV_DN || k == EV_BOTH);
        repeat (LAT) step();
        b_mode = 1'b0;
        b_up   = 1'b0;
        b_dn   = 1'b0;
        repeat (LAT) step();
    endtask

    task automatic set_cur(input logic [23:0] v);
        for (int i = 0; i < 6; i++) cur[i] = v[23-4*i -: 4];
    endtask

    task automatic model_reset();
        m_field = 0;
        m_blink = 1'b0;
        for (int i = 0; i < 6; i++) md[i] = 0;
        anchor = n_edge;
        ev_edge = -1;
    endtask

    initial begin
        set_cur(24'h123456);
        repeat (3) @(negedge clk);
        check_outputs();
        rst = 1'b0;
        model_reset();
        repeat (32) step();
        press(EV_MODE);
        repeat (11) press(EV_UP);
        press(EV_UP);
        press(EV_DN);
        press(EV_MODE);
        repeat (25) press(EV_UP);
        press(EV_UP);
        press(EV_DN);
        press(EV_MODE);
        press(EV_MODE);
        repeat (25) step();
        set_cur(24'h235959);
        repeat (12) step();
        set_cur(24'h235958);
        repeat (12) step();
        press(EV_MODE);
        for (int g = 1; g <= 3; g++) begin
            b_up = 1'b1;
            repeat (g) step();
            b_up = 1'b0;
            repeat (10) step();
        end
        press(EV_BOTH);
        press(EV_MODEUP);
        press(EV_UP);
        b_up = 1'b1;
        repeat (4) step();
        rst = 1'b1;
        b_up = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        model_reset();
        repeat (24) step();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 6; i++) cur[i] = 4'($urandom_range(0, 9));
            step();
            press(EV_MODE);
            for (int f = 0; f < 3; f++) begin
                repeat ($urandom_range(0, 3)) press(($urandom_range(0, 1) == 0) ? EV_UP : EV_DN);
                press(EV_MODE);
            end
            repeat (12) step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Controller that sequences the BCD time-of-day counter in the VGA clock display. It generates the 1 Hz count-enable tick from the 25 MHz pixel clock and forces 24-hour rollover. It also runs a three-button user edit mode (hours / minutes / seconds). On exit from edit mode it issues a single load strobe carrying the edited digits. It sits between the board buttons and the time counter, and drives the field-blink hint consumed by the display renderer.

## Interface
- CLK_HZ, 25_000_000: clock cycles per second; tick period.
- DEBOUNCE_CYCLES, 250_000: required stable cycles before a button level is accepted (10 ms).
- BLINK_HALF, 12_500_000: cycles per blink phase in edit mode.

- clk  in  1  system clock (25 MHz).
- reset  in  1  asynchronous, active-high.
- btn_mode, btn_up, btn_down  in  1 each  raw, unsynchronised, active-high buttons.
- cur_h_t, cur_h_u, cur_m_t, cur_m_u, cur_s_t, cur_s_u  in  4 each  current BCD time from the counter.
- tick  out  1  one-cycle count enable to the counter.
- load  out  1  one-cycle strobe: counter takes set_* digits; load has priority over tick in the counter.
- set_h_t, set_h_u, set_m_t, set_m_u, set_s_t, set_s_u  out  4 each  BCD load/edit value.
- edit_field  out  2  0 = none (RUN), 1 = hours, 2 = minutes, 3 = seconds.
- blink  out  1  blink phase for the field being edited; 0 in RUN.

## Operation
- FSM states and transitions:
  - RUN -> EDIT_H on a mode press; cur_* is copied into set_*.
  - EDIT_H -> EDIT_M -> EDIT_S, advancing on each mode press.
  - EDIT_S -> RUN on a mode press; load is pulsed on that exit.
- Button path, per button:
  - 2-FF synchroniser.
  - Debounce counter: the debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any reversion clears the counter.
  - A rising edge of the debounced level gives a one-cycle press pulse.
- Press priority:
  - mode press beats up/down in the same cycle; up/down are ignored.
  - up and down in the same cycle are both ignored.
- RUN state:
  - Prescaler counts 0..CLK_HZ-1 and wraps; tick = 1 when the count equals CLK_HZ-1.
  - up/down presses are ignored.
  - Rollover: if tick fires while cur_* = 23:59:59, load is asserted in the same cycle with set_* = 00:00:00.
- Edit states:
  - Prescaler is held at 0 and tick = 0.
  - up/down adjust only the selected field, as two-digit BCD.
  - Hours range 00..23: up from 23 gives 00, down from 00 gives 23.
  - Minutes and seconds range 00..59: up from 59 gives 00, down from 00 gives 59.
  - Units and tens carry/borrow correctly (09 up gives 10; 20 down gives 19).
  - The counter keeps its old value during edit; only set_* changes.
- set_* holds its value in RUN except on rollover load. Out-of-range cur_* copied on entry is taken as-is; the first up/down press clamps it to 00.
- blink:
  - Set to 1 on entering EDIT_H.
  - Toggles every BLINK_HALF cycles while in edit states.
  - Its counter restarts at each field change.
  - Forced to 0 in RUN.

## Timing
- Reset values: state RUN, all outputs 0, prescaler 0, debounced levels 0, blink counter 0.
- Latency from raw button edge to press pulse is 2 + DEBOUNCE_CYCLES + 1 cycles, assuming a stable input.
- Cycles after a press pulse:
  - state, edit_field and set_* update 1 cycle later (registered).
  - load rises 1 cycle after the final mode press and lasts exactly 1 cycle. set_* is stable during the load cycle and after it.
- The first tick after returning to RUN occurs CLK_HZ cycles after the load cycle.
- All outputs are registered; none depend combinationally on inputs.
- Reset asserted mid-edit:
  - Immediate return to RUN with no load and set_* = 0.
  - In-flight debounce state is discarded.

## Structure
- Shared package time_pkg holds:
  - state enum (RUN, EDIT_H, EDIT_M, EDIT_S);
  - edit_field codes;
  - BCD limits HOURS_MAX = 23 and MINSEC_MAX = 59;
  - BCD increment/decrement-with-limit functions.
- Sub-module btn_debounce (synchroniser + debounce + edge pulse) is instantiated three times.
- FSM, prescaler and blink logic stay in time_set_ctrl.

## Test plan
All scenarios use CLK_HZ=10, DEBOUNCE_CYCLES=4, BLINK_HALF=3.
- Reset release, RUN -> tick on cycles 10, 20, 30; load and edit_field stay 0; blink 0.
- cur = 12:34:56, mode press -> edit_field=1, set=12:34:56, tick stops. 11 up presses -> set hours 23; 1 more up -> 00; down -> 23.
- Advance to minutes and set 59; up -> 00, down -> 59. Mode twice -> one-cycle load with set=23:59:56, edit_field=0, next tick 10 cycles after the load.
- RUN with cur = 23:59:59 -> on the tick cycle, tick=1 and load=1 with set=00:00:00. With cur = 23:59:58 -> tick only.
- Glitches on btn_up of 1-3 cycles -> no press. up and down pressed in the same cycle -> set unchanged. mode+up together in EDIT_H -> moves to EDIT_M, hours unchanged.
- Reset asserted in EDIT_M -> all outputs 0 and RUN on the next edge, no load. First tick arrives 10 cycles after reset release.
